// File: rtl/id_pool_allocator_if.sv
// Handshake and status bundle for id_pool_allocator: allocation, release, flush and pool status.
// The master side is the issue/retire logic; the slave side is the allocator.
interface id_pool_allocator_if #(
    parameter int unsigned NUM_IDS = 8
);
    localparam int unsigned ID_W = $clog2(NUM_IDS);

    logic                alloc_req;
    logic                alloc_ack;
    logic [ID_W-1:0]     alloc_id;
    logic                release_valid;
    logic [ID_W-1:0]     release_id;
    logic                flush;
    logic [NUM_IDS-1:0]  in_use;
    logic [ID_W:0]       count;
    logic                full;
    logic                empty;
    logic                double_release;

    modport master (
        output alloc_req, release_valid, release_id, flush,
        input  alloc_ack, alloc_id, in_use, count, full, empty, double_release
    );

    modport slave (
        input  alloc_req, release_valid, release_id, flush,
        output alloc_ack, alloc_id, in_use, count, full, empty, double_release
    );
endinterface

// File: rtl/id_pool_allocator.sv
// Busy-vector ID pool: one combinational grant and one release per cycle, plus global flush.
// Optional round-robin search start enabled by ID_POOL_ALLOCATOR_RR_ALLOC_EN.
module id_pool_allocator #(
    parameter int unsigned NUM_IDS = 8
) (
    input logic              clk,
    input logic              rst,
    id_pool_allocator_if.slave bus
);
    localparam int unsigned ID_W = $clog2(NUM_IDS);
    localparam logic [ID_W:0] CountMax = (ID_W + 1)'(NUM_IDS);

    logic [NUM_IDS-1:0] in_use_q, in_use_d;
    logic [ID_W:0]      count_q, count_d;
    logic               dbl_q, dbl_d;

    logic               full, ack, found;
    logic [ID_W-1:0]    base, cand, pick;
    logic [NUM_IDS-1:0] set_mask, clr_mask;
    logic               rel_legal, rel_illegal;

`ifdef ID_POOL_ALLOCATOR_RR_ALLOC_EN
    logic [ID_W-1:0] ptr_q, ptr_d;

    assign base = ptr_q;

    always_comb begin
        ptr_d = ptr_q;
        if (bus.flush) begin
            ptr_d = '0;
        end else if (ack) begin
            ptr_d = pick + ID_W'(1);  // wraps naturally since NUM_IDS is a power of two
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    assign base = '0;
`endif

    // First free ID scanning upward from base, wrapping.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        for (int i = 0; i < NUM_IDS; i++) begin
            cand = base + ID_W'(i);
            if (!found && !in_use_q[cand]) begin
                pick  = cand;
                found = 1'b1;
            end
        end
    end

    assign full = (count_q == CountMax);
    // Gating with rst keeps the grant low for the whole asynchronous reset window.
    assign ack  = rst & bus.alloc_req & ~full & ~bus.flush;

    assign rel_legal   = bus.release_valid & in_use_q[bus.release_id];
    assign rel_illegal = bus.release_valid & ~in_use_q[bus.release_id];
    assign set_mask    = ack ? (NUM_IDS'(1) << pick) : '0;
    assign clr_mask    = rel_legal ? (NUM_IDS'(1) << bus.release_id) : '0;

    always_comb begin
        in_use_d = (in_use_q | set_mask) & ~clr_mask;
        count_d  = count_q;
        dbl_d    = dbl_q | rel_illegal;
        unique case ({ack, rel_legal})
            2'b10:   count_d = count_q + (ID_W + 1)'(1);
            2'b01:   count_d = count_q - (ID_W + 1)'(1);
            default: count_d = count_q;
        endcase
        if (bus.flush) begin
            in_use_d = '0;
            count_d  = '0;
            dbl_d    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in_use_q <= '0;
            count_q  <= '0;
            dbl_q    <= 1'b0;
        end else begin
            in_use_q <= in_use_d;
            count_q  <= count_d;
            dbl_q    <= dbl_d;
        end
    end

    assign bus.alloc_ack      = ack;
    assign bus.alloc_id       = pick;
    assign bus.in_use         = in_use_q;
    assign bus.count          = count_q;
    assign bus.full           = full;
    assign bus.empty          = (count_q == '0);
    assign bus.double_release = dbl_q;
endmodule

// File: tb/tb_id_pool_allocator.sv
// Scoreboard bench for id_pool_allocator (NUM_IDS=4): driver pushes model expectations,
// a negedge monitor pops and compares against the DUT outputs.
module tb_id_pool_allocator;
    localparam int N = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    id_pool_allocator_if #(.NUM_IDS(N)) bus ();

    id_pool_allocator #(.NUM_IDS(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        bit ack;
        int id;
        int in_use;
        int count;
        bit full;
        bit empty;
        bit dbl;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: a plain busy array, a sticky flag and a search start.
    bit   mbusy[N];
    bit   mdbl;
    int   mptr;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) mbusy[i] = 1'b0;
        mdbl = 1'b0;
        mptr = 0;
    endtask

    function automatic int model_count();
        int c = 0;
        for (int i = 0; i < N; i++) c += int'(mbusy[i]);
        return c;
    endfunction

    function automatic int model_vec();
        int v = 0;
        for (int i = 0; i < N; i++) if (mbusy[i]) v += (1 << i);
        return v;
    endfunction

    function automatic int model_pick();
        int start = 0;
`ifdef ID_POOL_ALLOCATOR_RR_ALLOC_EN
        start = mptr;
`endif
        for (int k = 0; k < N; k++) begin
            if (!mbusy[(start + k) % N]) return (start + k) % N;
        end
        return -1;
    endfunction

    // One clock cycle of stimulus: drive, record expectation, advance model.
    task automatic cyc(input bit req, input bit rv, input int rid, input bit fl);
        exp_t e;
        int   cnt;
        bit   legal;
        @(posedge clk);
        #1;
        bus.alloc_req     = req;
        bus.release_valid = rv;
        bus.release_id    = rid[1:0];
        bus.flush         = fl;
        cnt      = model_count();
        e.count  = cnt;
        e.in_use = model_vec();
        e.full   = (cnt == N);
        e.empty  = (cnt == 0);
        e.dbl    = mdbl;
        e.ack    = req && (cnt != N) && !fl;
        e.id     = model_pick();
        q.push_back(e);
        if (fl) begin
            model_reset();
        end else begin
            legal = mbusy[rid];
            if (rv && !legal) mdbl = 1'b1;
            if (rv && legal) mbusy[rid] = 1'b0;
            if (e.ack) begin
                mbusy[e.id] = 1'b1;
                mptr = (e.id + 1) % N;
            end
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("alloc_ack", int'(bus.alloc_ack), int'(e.ack));
                if (e.ack) chk("alloc_id", int'(bus.alloc_id), e.id);
                chk("in_use", int'(bus.in_use), e.in_use);
                chk("count", int'(bus.count), e.count);
                chk("full", int'(bus.full), int'(e.full));
                chk("empty", int'(bus.empty), int'(e.empty));
                chk("double_release", int'(bus.double_release), int'(e.dbl));
            end
        end
    end

    initial begin : driver
        int rid;
        bus.alloc_req     = 1'b0;
        bus.release_valid = 1'b0;
        bus.release_id    = '0;
        bus.flush         = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #2 bus.alloc_req = 1'b1;
        #1 chk("ack_in_reset", int'(bus.alloc_ack), 0);
        bus.alloc_req = 1'b0;
        @(negedge clk);
        rst = 1'b1;

        // Reset state, then fill the pool and see it saturate.
        cyc(0, 0, 0, 0);
        repeat (5) cyc(1, 0, 0, 0);
        // Release while full: no same-cycle grant, grant of 2 next cycle.
        cyc(1, 1, 2, 0);
        cyc(1, 0, 0, 0);
        cyc(0, 0, 0, 0);
        // Simultaneous alloc and legal release from 0011.
        cyc(0, 0, 0, 1);
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        cyc(1, 1, 0, 0);
        cyc(0, 0, 0, 0);
        // Illegal release is sticky until flush; flush also drops a same-cycle release.
        cyc(0, 0, 0, 1);
        cyc(1, 0, 0, 0);
        cyc(0, 1, 3, 0);
        cyc(0, 0, 0, 0);
        cyc(1, 1, 2, 0);
        cyc(1, 1, 0, 1);
        cyc(0, 0, 0, 0);
        // Round-robin sequence (lowest-free when the feature is off).
        cyc(1, 0, 0, 0);
        cyc(1, 1, 0, 0);
        repeat (3) cyc(1, 0, 0, 0);
        cyc(0, 0, 0, 0);

        // Build 1011, then drop reset away from any clock edge.
        cyc(0, 0, 0, 1);
        repeat (4) cyc(1, 0, 0, 0);
        cyc(0, 1, 2, 0);
        cyc(0, 0, 0, 0);
        @(negedge clk);
        #2;
        rst = 1'b0;
        bus.alloc_req = 1'b1;
        #1;
        chk("async_in_use", int'(bus.in_use), 0);
        chk("async_count", int'(bus.count), 0);
        chk("async_empty", int'(bus.empty), 1);
        chk("async_full", int'(bus.full), 0);
        chk("async_dbl", int'(bus.double_release), 0);
        chk("async_ack", int'(bus.alloc_ack), 0);
        repeat (2) @(posedge clk);
        #1 chk("held_reset_ack", int'(bus.alloc_ack), 0);
        chk("held_reset_in_use", int'(bus.in_use), 0);
        @(negedge clk);
        #2;
        bus.alloc_req = 1'b0;
        rst = 1'b1;
        model_reset();
        cyc(1, 0, 0, 0);
        cyc(0, 0, 0, 0);

        // Randomized traffic, releases biased toward busy IDs.
        for (int n = 0; n < 400; n++) begin
            rid = $urandom_range(N - 1);
            if ($urandom_range(3) != 0) begin
                for (int k = 0; k < N; k++) begin
                    if (mbusy[(rid + k) % N]) begin
                        rid = (rid + k) % N;
                        break;
                    end
                end
            end
            cyc($urandom_range(3) != 0, $urandom_range(1) == 1, rid, $urandom_range(40) == 0);
        end
        cyc(0, 0, 0, 0);
        @(negedge clk);
        #1;
        chk("queue_drained", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/id_pool_allocator.md
Name: id_pool_allocator

Overview:
- Tracks a pool of NUM_IDS in-flight identifiers (load/store tags, writeback IDs) using a per-ID busy vector.
- The vector is a set/clear register: allocation sets a bit, retirement clears it.
- Hands out one free ID per cycle to a single requester. Accepts one release per cycle from the retire path. Supports a global flush.
- Sits between the issue stage (allocation) and the writeback/retire logic (release).

Parameters:
- NUM_IDS, default 8: pool size. Power of two, minimum 2.
- ID_W, default $clog2(NUM_IDS): ID width. Derived; not overridden.

Ports:
- clk  in  1  clock.
- rst  in  1  reset.
- alloc_req  in  1  requester wants an ID this cycle.
- alloc_ack  out  1  ID granted this cycle.
- alloc_id  out  ID_W  granted ID. Valid only when alloc_ack=1.
- release_valid  in  1  retire path frees release_id.
- release_id  in  ID_W  ID being freed.
- flush  in  1  free all IDs.
- in_use  out  NUM_IDS  registered busy vector.
- count  out  ID_W+1  number of busy IDs.
- full  out  1  count==NUM_IDS.
- empty  out  1  count==0.
- double_release  out  1  sticky error flag.

Interface (already decided):
- One clock; reset is asynchronous and active-low.
- Clock port is clk; reset port is rst, active-low.

Behaviour:
- Reset values (rst=0, asynchronous):
  - in_use=0, count=0, empty=1, full=0, double_release=0.
  - Round-robin pointer (optional feature) = 0.
  - alloc_ack=0 while in reset.
- Grant (combinational, same cycle):
  - alloc_ack = alloc_req & ~full & ~flush.
  - alloc_id = lowest-index zero bit of the registered in_use.
  - Zero-cycle latency from request to grant.
- Grant takes effect next cycle:
  - in_use[alloc_id] is set and count increments on the next clk edge after a cycle with alloc_ack=1.
  - No request/ack hold requirement: an ungranted request is simply retried by the requester.
- Release takes effect next cycle:
  - If release_valid and in_use[release_id]=1: that bit clears and count decrements on the next edge.
  - If release_valid and in_use[release_id]=0: no state change; double_release is set (sticky).
- No bypass: a release in cycle N does not make that ID grantable in cycle N. When full, a same-cycle release does not enable a grant; the grant can occur at N+1.
- Simultaneous alloc and release:
  - Both apply; count is unchanged.
  - A grant and a release can never target the same ID, because the granted ID is free and a valid release targets a busy ID.
  - If the release is illegal, the grant still applies and double_release is set.
- Flush priority:
  - Next state is in_use=0, count=0, double_release=0, pointer=0.
  - A same-cycle release is ignored. alloc_ack=0.
- Status outputs:
  - full and empty are derived from registered count, so they are consistent with in_use in the same cycle.
  - count never exceeds NUM_IDS and never underflows.
- Update equation: in_use_next = (in_use | set_mask) & ~clr_mask, where set_mask and clr_mask are one-hot or zero. Flush overrides to 0.

Optional Feature:
- Macro: ID_POOL_ALLOCATOR_RR_ALLOC_EN.
- When defined:
  - A registered ID_W pointer holds (last granted ID + 1) mod NUM_IDS.
  - alloc_id = first free ID searching upward from the pointer, wrapping.
  - The pointer updates on every grant and resets to 0 on reset or flush.
  - Purpose: spreads tag reuse.
- When undefined:
  - No pointer register; lowest free index is always chosen.
  - All other behaviour is identical.

Test Plan (NUM_IDS=4):
1. Reset then alloc_req=1 for 4 cycles -> alloc_id 0,1,2,3 with alloc_ack=1; then full=1, count=4, alloc_ack=0 in cycle 5.
2. Full pool; release_id=2 with alloc_req=1 in the same cycle -> alloc_ack=0 that cycle; next cycle alloc_ack=1, alloc_id=2, count=4.
3. in_use=4'b0011; alloc_req=1 and release_id=0 in the same cycle -> alloc_id=2; next cycle in_use=4'b0110, count=2.
4. Release of ID 3 while in_use=4'b0001 -> in_use unchanged, double_release=1 and stays 1. Then flush=1 -> in_use=0, count=0, empty=1, double_release=0.
5. Assert rst=0 asynchronously mid-stream with in_use=4'b1011 -> outputs return to reset values without waiting for a clock edge. No grant until rst=1.
6. With ID_POOL_ALLOCATOR_RR_ALLOC_EN defined: grant 0,1; release 0; request -> alloc_id=2, then 3, then 0 (wrap).
